// File: rtl/event_filter_pkg.sv
// ============================================================================
// event_filter_pkg : shared constants, state and event types | rev 1.0
// ============================================================================
`default_nettype none

package event_filter_pkg;

  localparam int         EVT_W   = 6;
  localparam logic [1:0] P_VALID = 2'b11;
  localparam logic [1:0] P_IDLE  = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [1:0] t;
    logic [1:0] y;
    logic [1:0] x;
  } evt_t;

endpackage

`default_nettype wire

// File: rtl/event_filter_sequencer_if.sv
// ============================================================================
// event_filter_sequencer_if : source handshake and filter-side bus | rev 1.0
// ============================================================================
`default_nettype none

interface event_filter_sequencer_if #(
  parameter int N_SRC = 4,
  parameter int EVT_W = 6
);
  localparam int GID_W = $clog2(N_SRC);

  logic [N_SRC-1:0]       src_valid;
  logic [N_SRC*EVT_W-1:0] src_evt;
  logic [N_SRC-1:0]       src_ready;
  logic [EVT_W-1:0]       flt_evt;
  logic [1:0]             flt_p;
  logic [GID_W-1:0]       grant_id;

  modport master (
    input  src_valid, src_evt,
    output src_ready, flt_evt, flt_p, grant_id
  );

  modport slave (
    output src_valid, src_evt,
    input  src_ready, flt_evt, flt_p, grant_id
  );

endinterface

`default_nettype wire

// File: rtl/event_filter_sequencer_rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick starting at ptr | rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N_SRC = 4,
  parameter int IDX_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_idx = IDX_W'((int'(ptr) + k) % N_SRC);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/event_filter_sequencer.sv
// ============================================================================
// event_filter_sequencer : round-robin event front end with window flush | rev 1.0
// ============================================================================
`default_nettype none

module event_filter_sequencer #(
  parameter int N_SRC       = 4,
  parameter int WINDOW_SIZE = 4,
  parameter int EVT_W       = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  event_filter_sequencer_if.master        bus,
  input  logic                            flush_req,
  output logic                            flush_busy,
  output logic [3:0]                      fill_cnt,
  output logic                            window_full
);
  import event_filter_pkg::*;

  localparam int         GID_W   = $clog2(N_SRC);
  localparam logic [3:0] WIN_CNT = 4'(WINDOW_SIZE);

  seq_state_t       r_state;
  logic [GID_W-1:0] r_rr_ptr;
  logic [3:0]       r_flush_cnt;
  logic [EVT_W-1:0] r_flt_evt;
  logic [1:0]       r_flt_p;
  logic [GID_W-1:0] r_grant_id;
  logic [3:0]       r_fill_cnt;
  logic             r_flush_busy;

  logic             w_flush_take;
  logic             w_grant_en;
  logic             w_xfer;
  logic [N_SRC-1:0] w_req;
  logic [N_SRC-1:0] w_gnt;
  logic [GID_W-1:0] w_gnt_idx;
  logic [EVT_W-1:0] w_sel_evt;

  // A flush accepted this cycle suppresses any grant in the same cycle.
  assign w_flush_take = (r_state == ACTIVE) && flush_req;
  assign w_grant_en   = (r_state != FLUSH) && !w_flush_take;
  assign w_req        = bus.src_valid & {N_SRC{w_grant_en}};

  rr_arbiter #(
    .N_SRC (N_SRC),
    .IDX_W (GID_W)
  ) u_arb (
    .req     (w_req),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_xfer = |w_gnt;

  always_comb begin
    w_sel_evt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_gnt[i]) w_sel_evt = bus.src_evt[i*EVT_W +: EVT_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_flush_cnt  <= '0;
      r_flt_evt    <= '0;
      r_flt_p      <= P_IDLE;
      r_grant_id   <= '0;
      r_fill_cnt   <= '0;
      r_flush_busy <= 1'b0;
    end else begin
      r_flt_p <= P_IDLE;
      if (w_xfer) begin
        r_flt_evt  <= w_sel_evt;
        r_flt_p    <= P_VALID;
        r_grant_id <= w_gnt_idx;
        r_rr_ptr   <= (w_gnt_idx == GID_W'(N_SRC - 1)) ? '0 : w_gnt_idx + GID_W'(1);
        if (r_fill_cnt != WIN_CNT) r_fill_cnt <= r_fill_cnt + 4'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_xfer) r_state <= ACTIVE;
        end
        ACTIVE: begin
          if (flush_req) begin
            r_state      <= FLUSH;
            r_flush_cnt  <= '0;
            r_flush_busy <= 1'b1;
            r_flt_evt    <= '0;
            r_flt_p      <= P_VALID;
          end
        end
        FLUSH: begin
          // Each flush cycle pushes a zero event; occupancy clears only on exit.
          if (r_flush_cnt == WIN_CNT - 4'd1) begin
            r_state      <= IDLE;
            r_flush_busy <= 1'b0;
            r_fill_cnt   <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + 4'd1;
            r_flt_evt   <= '0;
            r_flt_p     <= P_VALID;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.src_ready = w_gnt;
  assign bus.flt_evt   = r_flt_evt;
  assign bus.flt_p     = r_flt_p;
  assign bus.grant_id  = r_grant_id;
  assign flush_busy    = r_flush_busy;
  assign fill_cnt      = r_fill_cnt;
  assign window_full   = (r_fill_cnt == WIN_CNT);

endmodule

`default_nettype wire

// File: doc/event_filter_sequencer.md
# event_filter_sequencer

Front-end controller for the event-based moving-average filter. It shares the filter's single event input between `N_SRC` event sources using round-robin arbitration, and drives the filter's 6-bit event bus and 2-bit valid code. It tracks window occupancy and runs a flush sequence that pushes `WINDOW_SIZE` zero events to drain the window. It sits directly upstream of the filter, between the sensor front-ends and the datapath.

## Interface
Parameters:
- `N_SRC`, 4: number of requesting event sources (2..8).
- `WINDOW_SIZE`, 4: filter window depth; must match the filter instance.
- `EVT_W`, 6: event width, packed `{t[1:0], y[1:0], x[1:0]}`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `src_valid`  in  N_SRC  per-source event valid.
- `src_evt`  in  N_SRC*EVT_W  per-source event; source i occupies bits `[i*EVT_W +: EVT_W]`.
- `src_ready`  out  N_SRC  one-hot grant, combinational; transfer when `src_valid[i] & src_ready[i]`.
- `flush_req`  in  1  single-cycle pulse requesting a window drain.
- `flush_busy`  out  1  high while in FLUSH.
- `flt_evt`  out  EVT_W  registered event to the filter.
- `flt_p`  out  2  registered valid code to the filter: `2'b11` = event present, `2'b00` = idle.
- `grant_id`  out  $clog2(N_SRC)  registered index of the source behind the current `flt_evt`.
- `fill_cnt`  out  4  registered window occupancy, 0..WINDOW_SIZE.
- `window_full`  out  1  `fill_cnt == WINDOW_SIZE`.

## Operation
- **FSM states:** IDLE, ACTIVE, FLUSH.
- **IDLE → ACTIVE:** on the first accepted transfer.
- **ACTIVE → FLUSH:** on `flush_req`.
- **FLUSH → IDLE:** after exactly `WINDOW_SIZE` flush cycles.
- **`flush_req` in IDLE:** ignored; the window is already empty.
- **`flush_req` in FLUSH:** ignored.
- **Arbitration:** round-robin pointer `rr_ptr`, reset 0.
  - In IDLE or ACTIVE, grant the first requesting source at or after `rr_ptr`, wrapping modulo `N_SRC`.
  - After a grant to source i, `rr_ptr <= (i+1) mod N_SRC`.
  - With no requests, `rr_ptr` holds.
  - At most one grant per cycle.
- **Flush priority:** `flush_req` in ACTIVE wins over any `src_valid` in the same cycle. No grant is issued that cycle and `src_ready` is all zero.
- **In FLUSH:** `src_ready` is all zero. Each cycle drives `flt_evt = 0` and `flt_p = 2'b11` (a zero event that displaces the oldest sample).
- **`fill_cnt` update:**
  - +1 per accepted transfer, saturating at `WINDOW_SIZE`.
  - Unchanged by flush cycles until FLUSH exits, then set to 0 on the exit edge.
- **No-transfer cycle outside FLUSH:** `flt_p = 2'b00`, and `flt_evt` holds its last value.

## Timing
- **Reset values:** `flt_evt = 0`, `flt_p = 0`, `grant_id = 0`, `fill_cnt = 0`, `window_full = 0`, `flush_busy = 0`, state IDLE, `rr_ptr = 0`.
- **Grant to filter latency:** 1 cycle. A transfer at edge n appears on `flt_evt`/`flt_p`/`grant_id` after edge n.
- **`src_ready`:** combinational from `src_valid`, `rr_ptr` and state; no combinational path from `flt_*`.
- **`flush_busy`:** rises the cycle after the accepting edge and stays high for `WINDOW_SIZE` cycles. `flt_p = 2'b11` on each of those cycles.
- **Reset mid-FLUSH:** returns immediately to reset values; the remaining flush cycles are abandoned.
- **Sustained requests:** all `N_SRC` sources valid continuously gives grants in order `rr_ptr, rr_ptr+1, …`, one per cycle, with no bubbles.

## Structure
- **Shared package `event_filter_pkg`:**
  - constants `EVT_W`, `P_VALID = 2'b11`, `P_IDLE = 2'b00`;
  - state enum `seq_state_t {IDLE, ACTIVE, FLUSH}`;
  - event struct fields `x`, `y`, `t`.
- **Sub-module `rr_arbiter`:** parameterised by `N_SRC`; inputs `req`, `ptr`; outputs one-hot `gnt` and `gnt_idx`; purely combinational.
- **Top level:** FSM, pointer, flush counter (counts 0..WINDOW_SIZE-1), output registers.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream → all outputs 0 within the same cycle. Release and idle 5 cycles → `flt_p = 0`, `fill_cnt = 0`.
- **Round-robin sweep:** `src_valid = 4'b1111` for 8 cycles with `src_evt[i] = 6'h10+i` → `grant_id` sequence 0,1,2,3,0,1,2,3 one cycle after each grant. `flt_p = 2'b11` throughout. `fill_cnt` reads 1,2,3,4,4…, and `window_full` is set from the 4th event.
- **Skip and wrap:** `rr_ptr = 3`, `src_valid = 4'b0101` → grant source 0, then source 2, then 0.
- **Flush:** after 4 events, pulse `flush_req` together with `src_valid = 4'b0010` → no grant that cycle. `flush_busy` high for 4 cycles with `flt_evt = 0`, `flt_p = 2'b11`. Then `fill_cnt = 0`, state IDLE, and source 1 is granted on the next cycle.
- **Flush in IDLE:** pulse `flush_req` with `fill_cnt = 0` → `flush_busy` stays 0 and `flt_p` stays 0.
- **Reset during FLUSH:** drop `rst_n` on the 2nd flush cycle → `flush_busy = 0` and `fill_cnt = 0` immediately. After release, the first valid request is granted normally starting from source 0.
